// File: rtl/shift_exec_unit.sv
// Multi-cycle MIPS shift unit: decodes R-type shift functs, one bit per cycle.
// Define SHIFT_EXEC_FAST_EN for a single-cycle barrel-shifter variant.
module shift_exec_unit #(
  parameter int DATA_W = 32,
  parameter int SA_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [5:0]        funct,
  input  logic [SA_W-1:0]   shamt,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  output logic              eshift,
  output logic [DATA_W-1:0] sa,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              illegal
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_SLL,
    OP_SRL,
    OP_SRA
  } op_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_work;
  logic              r_eshift;
  logic [DATA_W-1:0] r_sa;
  logic [DATA_W-1:0] r_result;
  logic              r_done;
  logic              r_illegal;

  logic              w_legal;
  logic              w_eshift;
  op_t               w_op;
  logic [SA_W-1:0]   w_amt;
  logic              w_unused_rs;

  // Only the low SA_W bits of rs select the variable amount.
  assign w_unused_rs = ^rs_val[DATA_W-1:SA_W];

  always_comb begin
    w_legal  = 1'b1;
    w_eshift = 1'b1;
    w_op     = OP_SLL;
    case (funct)
      6'b000000: begin w_eshift = 1'b1; w_op = OP_SLL; end
      6'b000010: begin w_eshift = 1'b1; w_op = OP_SRL; end
      6'b000011: begin w_eshift = 1'b1; w_op = OP_SRA; end
      6'b000100: begin w_eshift = 1'b0; w_op = OP_SLL; end
      6'b000110: begin w_eshift = 1'b0; w_op = OP_SRL; end
      6'b000111: begin w_eshift = 1'b0; w_op = OP_SRA; end
      default:   w_legal = 1'b0;
    endcase
  end

  assign w_amt = w_eshift ? shamt : rs_val[SA_W-1:0];

`ifdef SHIFT_EXEC_FAST_EN
  logic [DATA_W-1:0] w_barrel;

  always_comb begin
    w_barrel = rt_val;
    case (w_op)
      OP_SLL:  w_barrel = rt_val << w_amt;
      OP_SRL:  w_barrel = rt_val >> w_amt;
      OP_SRA:  w_barrel = DATA_W'($signed(rt_val) >>> w_amt);
      default: w_barrel = rt_val;
    endcase
  end
`else
  logic [SA_W-1:0]   r_cnt;
  op_t               r_op;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_work    <= '0;
      r_eshift  <= 1'b0;
      r_sa      <= '0;
      r_result  <= '0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
`ifndef SHIFT_EXEC_FAST_EN
      r_cnt     <= '0;
      r_op      <= OP_SLL;
`endif
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_legal) begin
              r_eshift <= w_eshift;
              r_sa     <= {{(DATA_W-SA_W){1'b0}}, w_amt};
`ifdef SHIFT_EXEC_FAST_EN
              r_work   <= w_barrel;
              r_state  <= S_DONE;
`else
              r_work   <= rt_val;
              r_cnt    <= w_amt;
              r_op     <= w_op;
              r_state  <= (w_amt == '0) ? S_DONE : S_SHIFT;
`endif
            end else begin
              r_illegal <= 1'b1;
            end
          end
        end
`ifndef SHIFT_EXEC_FAST_EN
        S_SHIFT: begin
          case (r_op)
            OP_SLL:  r_work <= {r_work[DATA_W-2:0], 1'b0};
            OP_SRL:  r_work <= {1'b0, r_work[DATA_W-1:1]};
            OP_SRA:  r_work <= {r_work[DATA_W-1], r_work[DATA_W-1:1]};
            default: r_work <= r_work;
          endcase
          r_cnt <= r_cnt - SA_W'(1);
          if (r_cnt == SA_W'(1)) r_state <= S_DONE;
        end
`endif
        S_DONE: begin
          r_result <= r_work;
          r_done   <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign eshift  = r_eshift;
  assign sa      = r_sa;
  assign busy    = (r_state == S_SHIFT);
  assign done    = r_done;
  assign result  = r_result;
  assign illegal = r_illegal;

endmodule

// File: tb/tb_shift_exec_unit.sv
// Directed bench for shift_exec_unit: latency, busy span, decode, illegal, reset abort.
// Honors SHIFT_EXEC_FAST_EN for expected latency and busy.
module tb_shift_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        eshift;
  logic [31:0] sa;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  shift_exec_unit #(.DATA_W(32), .SA_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .funct  (funct),
    .shamt  (shamt),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .eshift (eshift),
    .sa     (sa),
    .busy   (busy),
    .done   (done),
    .result (result),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, optionally poke a stray start at sample index inj, then
  // wait (bounded) for done and check decode, latency, busy span, result.
  task automatic run_op(input string tag, input logic [5:0] f,
                        input logic [4:0] sh, input logic [31:0] rs,
                        input logic [31:0] rt, input logic exp_es,
                        input int amt, input logic [31:0] exp_res,
                        input int inj);
    int k;
    int bc;
    int exp_lat;
    int exp_busy;
`ifdef SHIFT_EXEC_FAST_EN
    exp_lat  = 1;
    exp_busy = 0;
`else
    exp_lat  = amt + 1;
    exp_busy = amt;
`endif
    @(negedge clk);
    start = 1'b1; funct = f; shamt = sh; rs_val = rs; rt_val = rt;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".eshift"}, {31'd0, eshift}, {31'd0, exp_es});
    chk({tag, ".sa"}, sa, amt);
    k  = 0;
    bc = 0;
    while (done !== 1'b1 && k < 64) begin
      bc += int'(busy);
      if (inj != 0 && k == inj) begin
        start = 1'b1; funct = 6'b000010; shamt = 5'd3;
        rt_val = 32'hFFFF_0000;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    chk({tag, ".latency"}, k, exp_lat);
    chk({tag, ".busy_cycles"}, bc, exp_busy);
    chk({tag, ".result"}, result, exp_res);
    chk({tag, ".sa_held"}, sa, amt);
    @(negedge clk);
    chk({tag, ".done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int dc;
    rst = 1'b1; start = 1'b0; funct = '0; shamt = '0;
    rs_val = '0; rt_val = '0;
    repeat (3) @(negedge clk);
    chk("rst.eshift", {31'd0, eshift}, 32'd0);
    chk("rst.sa", sa, 32'd0);
    chk("rst.busy", {31'd0, busy}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.result", result, 32'd0);
    chk("rst.illegal", {31'd0, illegal}, 32'd0);
    rst = 1'b0;

    run_op("sll4", 6'b000000, 5'd4, 32'h0, 32'h0000_000F,
           1'b1, 4, 32'h0000_00F0, 0);
    run_op("srav8", 6'b000111, 5'd0, 32'hFFFF_FFE8, 32'h8000_0000,
           1'b0, 8, 32'hFF80_0000, 0);
    run_op("srl0", 6'b000010, 5'd0, 32'h0, 32'h1234_5678,
           1'b1, 0, 32'h1234_5678, 0);

    @(negedge clk);
    start = 1'b1; funct = 6'b100000; shamt = 5'd7;
    rs_val = 32'h5; rt_val = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    chk("illegal.pulse", {31'd0, illegal}, 32'd1);
    chk("illegal.eshift", {31'd0, eshift}, 32'd1);
    chk("illegal.sa", sa, 32'd0);
    chk("illegal.result", result, 32'h1234_5678);
    chk("illegal.busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("illegal.clear", {31'd0, illegal}, 32'd0);
    chk("illegal.no_done", {31'd0, done}, 32'd0);

    run_op("sll31", 6'b000000, 5'd31, 32'h0, 32'h0000_0001,
           1'b1, 31, 32'h8000_0000, 3);
    run_op("sra31", 6'b000011, 5'd31, 32'h0, 32'h8000_0000,
           1'b1, 31, 32'hFFFF_FFFF, 0);
    run_op("srlv3", 6'b000110, 5'd9, 32'h0000_0023, 32'hF000_0000,
           1'b0, 3, 32'h1E00_0000, 0);

    @(negedge clk);
    start = 1'b1; funct = 6'b000100; shamt = 5'd0;
    rs_val = 32'd20; rt_val = 32'h0000_0005;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.eshift", {31'd0, eshift}, 32'd0);
    chk("abort.sa", sa, 32'd0);
    chk("abort.busy", {31'd0, busy}, 32'd0);
    chk("abort.done", {31'd0, done}, 32'd0);
    chk("abort.result", result, 32'd0);
    chk("abort.illegal", {31'd0, illegal}, 32'd0);
    dc = 0;
    repeat (30) begin
      @(negedge clk);
      dc += int'(done);
    end
    chk("abort.no_done", dc, 0);

    run_op("sll1", 6'b000000, 5'd1, 32'h0, 32'h0000_0001,
           1'b1, 1, 32'h0000_0002, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_exec_unit.md
Name: shift_exec_unit

Overview:
- Multi-cycle shift execution unit for the MIPS datapath.
- Decodes the R-type shift funct code, drives the shift-select pair (eshift, sa) consumed by the ALU operand-A select stage, and performs the shift iteratively, one bit per cycle.
- Start/busy/done handshake with the control unit; stalls the pipeline while busy.

Parameters:
- DATA_W, 32, operand/result width.
- SA_W, 5, shift-amount width; equals log2(DATA_W).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only in IDLE.
- funct  input  6  R-type funct field; sampled on accept.
- shamt  input  SA_W  instruction shamt field; sampled on accept.
- rs_val  input  DATA_W  rs operand; bits [SA_W-1:0] give the variable amount.
- rt_val  input  DATA_W  value to be shifted.
- eshift  output  1  1 = immediate shamt form, 0 = variable (register) form.
- sa  output  DATA_W  amount actually used, zero-extended.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse when result is valid.
- result  output  DATA_W  shifted value; held until the next accept.
- illegal  output  1  one-cycle pulse when start arrives with a non-shift funct.

Behaviour:
- Reset: state IDLE; eshift=0, sa=0, busy=0, done=0, result=0, illegal=0.
- Reset asserted mid-operation aborts the shift. The unit returns to IDLE next edge and result is cleared, with no done pulse.
- Decode on accept (start=1 in IDLE):
  - sll 000000 / srl 000010 / sra 000011 → eshift=1, amount=shamt.
  - sllv 000100 / srlv 000110 / srav 000111 → eshift=0, amount=rs_val[SA_W-1:0].
  - Any other funct → illegal=1 for one cycle. State stays IDLE; eshift, sa and result are unchanged.
- eshift and sa are registered on accept and held stable until the next accept.
- Internal regs: work (DATA_W), cnt (SA_W), op kind (left / logical right / arithmetic right).
- States:
  - IDLE: on a legal accept, work←rt_val and cnt←amount. Go to DONE if amount=0, else go to SHIFT.
  - SHIFT: each cycle work shifts by 1 (left: zero fill; srl: zero fill; sra: replicate bit DATA_W-1) and cnt decrements. When cnt reaches 1, the last shift occurs and the state goes to DONE.
  - DONE: result←work, done=1 for one cycle, then IDLE.
- Latency: accept at edge N; done high in the cycle following edge N+1+amount. amount=0 gives done after edge N+1 with result=rt_val. amount=31 gives 32 cycles.
- busy=1 exactly in SHIFT. busy is 0 in DONE.
- start while SHIFT or DONE is ignored, with no queuing. The next accept is possible in the cycle after done.
- start held continuously: a new operation is accepted in every IDLE cycle.
- Only the low SA_W bits of rs_val are used; upper bits are ignored.
- sra on a negative value: the sign bit is preserved every step. 0x80000000 sra 31 = 0xFFFFFFFF.

Optional Feature:
- Macro SHIFT_EXEC_FAST_EN.
- Defined: SHIFT is bypassed. A combinational barrel shifter computes the result at accept, so the unit goes IDLE→DONE for every legal op. Latency is fixed at 1 cycle (done after edge N+1), and busy is never asserted. Decode, eshift/sa, illegal and reset behaviour are identical.
- Undefined: iterative one-bit-per-cycle behaviour as above.

Test Plan:
- Reset, then sll funct=000000, shamt=4, rt=0x0000000F → eshift=1, sa=4, busy for 4 cycles, done with result=0x000000F0.
- srav funct=000111, rs=0xFFFFFFE8 (amount 8), rt=0x80000000 → eshift=0, sa=8, result=0xFF800000 after 9 cycles. Upper rs bits are ignored.
- srl funct=000010, shamt=0, rt=0x12345678 → no busy, done on the next cycle with result=0x12345678.
- Start funct=100000 (add) → illegal pulse, eshift/sa/result unchanged, state stays IDLE. A start during SHIFT of sll 31 is ignored, and the final result is 0x80000000 for rt=1.
- rst asserted 3 cycles into sllv with amount 20 → next cycle all outputs are 0, no done pulse. A following sll shamt=1, rt=1 gives result=2.
- With SHIFT_EXEC_FAST_EN: sra shamt=31, rt=0x80000000 → done 1 cycle after accept, result=0xFFFFFFFF, busy never high.
